// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
//   rob_kind_t   : instruction class held in each entry
//   rob_entry_t  : one reorder-buffer slot
//   ROB_TAG_W    : default tag width (capacity 2^ROB_TAG_W-1 entries)
//   ROB_XLEN     : data/PC width stored in an entry
//   ROB_NULL_TAG : tag 0, meaning "value ready, no producer"
package reorder_buffer_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int ROB_XLEN  = 32;
  localparam logic [ROB_TAG_W-1:0] ROB_NULL_TAG = '0;

  typedef enum logic [1:0] {
    ALU    = 2'd0,
    LOAD   = 2'd1,
    STORE  = 2'd2,
    BRANCH = 2'd3
  } rob_kind_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    rob_kind_t           kind;
    logic [4:0]          dest;
    logic [ROB_XLEN-1:0] value;
    logic                mispredict;
    logic [ROB_XLEN-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_tag_incr.sv
// ROB tag incrementer: next tag in the sequence 1..2^TAG_W-1, wrapping
// from the largest tag back to 1 so tag 0 (null producer) is never issued.
//   tag      in  TAG_W  current head/tail tag
//   tag_next out TAG_W  following tag
module reorder_buffer_rob_tag_incr #(
  parameter int TAG_W = 4
) (
  input  logic [TAG_W-1:0] tag,
  output logic [TAG_W-1:0] tag_next
);

  assign tag_next = (tag == {TAG_W{1'b1}}) ? TAG_W'(1) : tag + 1'b1;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the Tomasulo core.
// Allocates a tag per issued instruction, captures CDB results, serves
// operand values for completed-but-uncommitted tags and retires one entry
// per cycle from the head. A retiring mispredicted branch raises flush,
// which empties the buffer and redirects fetch.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alloc_valid/ready/kind/dest/tag issue-side allocation handshake
//   cdb_valid/tag/value/mispredict/target  result broadcast
//   rd_tag_j/k -> rd_ready_j/k, rd_value_j/k  operand lookups
//   commit_valid/ROB/dest/value, RegWrite, store_commit  retirement
//   flush, redirect_pc              mispredict recovery
//
// Optional feature: define ROB_CDB_BYPASS_EN to let the read ports forward
// a same-cycle CDB broadcast; otherwise they see stored entries only.
// XLEN must equal ROB_XLEN since entries use the package struct.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int XLEN  = ROB_XLEN,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [1:0]       alloc_kind,
  input  logic [4:0]       alloc_dest,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_mispredict,
  input  logic [XLEN-1:0]  cdb_target,
  input  logic [TAG_W-1:0] rd_tag_j,
  input  logic [TAG_W-1:0] rd_tag_k,
  output logic             rd_ready_j,
  output logic             rd_ready_k,
  output logic [XLEN-1:0]  rd_value_j,
  output logic [XLEN-1:0]  rd_value_k,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_ROB,
  output logic [4:0]       commit_dest,
  output logic [XLEN-1:0]  commit_value,
  output logic             RegWrite,
  output logic             store_commit,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc
);

  localparam int DEPTH = (1 << TAG_W) - 1;
  localparam logic [TAG_W-1:0] DEPTH_T   = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] NULL_TAG  = TAG_W'(ROB_NULL_TAG);

  // Slot 0 is tied to an always-invalid entry so any tag indexes safely.
  rob_entry_t ent [0:DEPTH];
  assign ent[0] = '0;

  logic [TAG_W-1:0] head_reg, head_next, head_inc;
  logic [TAG_W-1:0] tail_reg, tail_next, tail_inc;
  logic [TAG_W-1:0] count_reg, count_next;
  rob_entry_t       head_ent;
  logic             alloc_fire, wb_fire;
  logic             byp_j, byp_k;

  reorder_buffer_rob_tag_incr #(.TAG_W(TAG_W)) u_head_incr (.tag(head_reg), .tag_next(head_inc));
  reorder_buffer_rob_tag_incr #(.TAG_W(TAG_W)) u_tail_incr (.tag(tail_reg), .tag_next(tail_inc));

  // ---------------- head-side retirement ----------------
  always_comb begin
    head_ent     = ent[head_reg];
    commit_valid = head_ent.valid & head_ent.ready;
    flush        = commit_valid & (head_ent.kind == BRANCH) & head_ent.mispredict;
    commit_ROB   = commit_valid ? head_reg : '0;
    commit_dest  = commit_valid ? head_ent.dest : '0;
    commit_value = commit_valid ? head_ent.value : '0;
    RegWrite     = commit_valid & ((head_ent.kind == ALU) | (head_ent.kind == LOAD))
                   & (head_ent.dest != 5'd0);
    store_commit = commit_valid & (head_ent.kind == STORE);
    redirect_pc  = flush ? head_ent.target : '0;
  end

  // Registered count: a commit in the full cycle frees a slot only next cycle.
  assign alloc_ready = (count_reg < DEPTH_T) & ~flush;
  assign alloc_tag   = tail_reg;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign wb_fire     = cdb_valid & (cdb_tag != NULL_TAG) & ent[cdb_tag].valid;

  // ---------------- pointers and occupancy ----------------
  always_comb begin
    head_next  = commit_valid ? head_inc : head_reg;
    tail_next  = alloc_fire ? tail_inc : tail_reg;
    count_next = count_reg;
    if (alloc_fire && !commit_valid) begin
      count_next = count_reg + 1'b1;
    end else if (!alloc_fire && commit_valid) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg  <= TAG_FIRST;
      tail_reg  <= TAG_FIRST;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ---------------- entry storage ----------------
  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
      rob_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          entry_reg <= '0;
        end else begin
          if (alloc_fire && (tail_reg == TAG_W'(gi))) begin
            entry_reg.valid      <= 1'b1;
            entry_reg.ready      <= 1'b0;
            entry_reg.kind       <= rob_kind_t'(alloc_kind);
            entry_reg.dest       <= alloc_dest;
            entry_reg.value      <= '0;
            entry_reg.mispredict <= 1'b0;
            entry_reg.target     <= '0;
          end
          if (wb_fire && (cdb_tag == TAG_W'(gi))) begin
            entry_reg.ready      <= 1'b1;
            entry_reg.value      <= cdb_value;
            entry_reg.mispredict <= cdb_mispredict;
            entry_reg.target     <= cdb_target;
          end
          // Retirement wins over anything else landing on the head slot.
          if (commit_valid && (head_reg == TAG_W'(gi))) begin
            entry_reg <= '0;
          end
        end
      end

      assign ent[gi] = entry_reg;
    end
  endgenerate

  // ---------------- operand read ports ----------------
`ifdef ROB_CDB_BYPASS_EN
  assign byp_j = cdb_valid & (cdb_tag == rd_tag_j);
  assign byp_k = cdb_valid & (cdb_tag == rd_tag_k);
`else
  assign byp_j = 1'b0;
  assign byp_k = 1'b0;
`endif

  // Returns {ready, value}; the null tag always reads as a ready zero.
  function automatic logic [XLEN:0] rd_lookup(input logic [TAG_W-1:0] tag,
                                              input rob_entry_t       e,
                                              input logic             byp,
                                              input logic [XLEN-1:0]  cval);
    logic [XLEN:0] r;
    r = {e.valid & e.ready, e.value};
    if (byp) r = {1'b1, cval};
    if (tag == NULL_TAG) r = {1'b1, {XLEN{1'b0}}};
    return r;
  endfunction

  always_comb begin
    {rd_ready_j, rd_value_j} = rd_lookup(rd_tag_j, ent[rd_tag_j], byp_j, cdb_value);
    {rd_ready_k, rd_value_k} = rd_lookup(rd_tag_k, ent[rd_tag_k], byp_k, cdb_value);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_ready;
  logic [1:0]  alloc_kind;
  logic [4:0]  alloc_dest;
  logic [3:0]  alloc_tag;
  logic        cdb_valid, cdb_mispredict;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_target;
  logic [3:0]  rd_tag_j, rd_tag_k;
  logic        rd_ready_j, rd_ready_k;
  logic [31:0] rd_value_j, rd_value_k;
  logic        commit_valid, RegWrite, store_commit, flush;
  logic [3:0]  commit_ROB;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value, redirect_pc;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
    .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rd_tag_j(rd_tag_j), .rd_tag_k(rd_tag_k),
    .rd_ready_j(rd_ready_j), .rd_ready_k(rd_ready_k),
    .rd_value_j(rd_value_j), .rd_value_k(rd_value_k),
    .commit_valid(commit_valid), .commit_ROB(commit_ROB), .commit_dest(commit_dest),
    .commit_value(commit_value), .RegWrite(RegWrite), .store_commit(store_commit),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic rst; logic av; logic [1:0] kind; logic [4:0] dest;
    logic cvld; logic [3:0] ctag; logic [31:0] cval; logic mis; logic [31:0] tgt;
    logic [3:0] rj; logic [3:0] rk;
  } in_t;

  typedef struct packed {
    logic ar; logic [3:0] at; logic cv; logic [3:0] crob; logic [4:0] cdest;
    logic [31:0] cval; logic rw; logic st; logic fl; logic [31:0] rpc;
    logic rrj; logic [31:0] rvj; logic rrk; logic [31:0] rvk;
  } out_t;

  typedef struct {
    string name; in_t in; out_t exp; bit chk;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic in_t mi(logic av, logic [1:0] kind, logic [4:0] dest, logic cvld,
                             logic [3:0] ctag, logic [31:0] cval);
    return '{1'b0, av, kind, dest, cvld, ctag, cval, 1'b0, 32'h0, 4'h0, 4'h0};
  endfunction
  function automatic in_t idle_in();
    return mi(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0);
  endfunction
  function automatic in_t al(logic [1:0] kind, logic [4:0] dest);
    return mi(1'b1, kind, dest, 1'b0, 4'd0, 32'h0);
  endfunction
  function automatic in_t wb(logic [3:0] tag, logic [31:0] val);
    return mi(1'b0, 2'd0, 5'd0, 1'b1, tag, val);
  endfunction
  // Nothing retiring; both read ports on tag 0.
  function automatic out_t quiet(logic [3:0] at);
    return '{1'b1, at, 1'b0, 4'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             1'b1, 32'h0, 1'b1, 32'h0};
  endfunction
  function automatic out_t cm(logic [3:0] at, logic [3:0] crob, logic [4:0] dest,
                              logic [31:0] val, logic rw);
    out_t o;
    o = quiet(at);
    o.cv = 1'b1; o.crob = crob; o.cdest = dest; o.cval = val; o.rw = rw;
    return o;
  endfunction

  task automatic add(string n, in_t i, out_t e, bit c);
    vec_t v;
    v.name = n; v.in = i; v.exp = e; v.chk = c;
    vecs.push_back(v);
  endtask

  task automatic apply(in_t i);
    reset = i.rst; alloc_valid = i.av; alloc_kind = i.kind; alloc_dest = i.dest;
    cdb_valid = i.cvld; cdb_tag = i.ctag; cdb_value = i.cval;
    cdb_mispredict = i.mis; cdb_target = i.tgt; rd_tag_j = i.rj; rd_tag_k = i.rk;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  in_t  vi;
  out_t vo, act;

  initial begin
    apply(idle_in());
    reset = 1'b1;

    // ---------------- table ----------------
    vi = idle_in(); vi.rst = 1'b1;
    add("reset0", vi, quiet(1), 0);
    add("reset1", vi, quiet(1), 0);
    add("reset_state", idle_in(), quiet(1), 1);
    // Out-of-order writeback, in-order commit
    add("alloc_t1", al(ALU, 5), quiet(1), 1);
    add("alloc_t2", al(ALU, 6), quiet(2), 1);
    add("alloc_t3", al(ALU, 7), quiet(3), 1);
    vi = wb(3, 32'h33); vi.rk = 3;
    vo = quiet(4); vo.rrk = BYP; vo.rvk = BYP ? 32'h33 : 32'h0;
    add("wb_t3_bypass", vi, vo, 1);
    vi = wb(1, 32'h11); vi.rj = 3;
    vo = quiet(4); vo.rrj = 1'b1; vo.rvj = 32'h33;
    add("wb_t1_rd_t3", vi, vo, 1);
    add("commit_t1", wb(2, 32'h22), cm(4, 1, 5, 32'h11, 1), 1);
    add("commit_t2", idle_in(), cm(4, 2, 6, 32'h22, 1), 1);
    add("commit_t3", idle_in(), cm(4, 3, 7, 32'h33, 1), 1);
    vi = idle_in(); vi.rj = 3;
    vo = quiet(4); vo.rrj = 1'b0;
    add("rd_retired_t3", vi, vo, 1);
    // Read ports
    add("alloc_t4", al(ALU, 1), quiet(4), 1);
    add("alloc_t5", al(ALU, 2), quiet(5), 1);
    vi = al(ALU, 3); vi.cvld = 1'b1; vi.ctag = 5; vi.cval = 32'h55;
    add("alloc_t6_wb_t5", vi, quiet(6), 1);
    vi = wb(6, 32'h66); vi.rj = 5; vi.rk = 6;
    vo = quiet(7); vo.rrj = 1'b1; vo.rvj = 32'h55;
    vo.rrk = BYP; vo.rvk = BYP ? 32'h66 : 32'h0;
    add("rd_t5_t6_same_cycle", vi, vo, 1);
    vi = wb(4, 32'h44); vi.rk = 6;
    vo = quiet(7); vo.rrk = 1'b1; vo.rvk = 32'h66;
    add("rd_t6_next_cycle", vi, vo, 1);
    add("commit_t4", idle_in(), cm(7, 4, 1, 32'h44, 1), 1);
    add("commit_t5", idle_in(), cm(7, 5, 2, 32'h55, 1), 1);
    add("commit_t6", idle_in(), cm(7, 6, 3, 32'h66, 1), 1);
    add("empty_t7", idle_in(), quiet(7), 1);
    // Store retirement
    add("alloc_store_t7", al(STORE, 0), quiet(7), 1);
    add("wb_store_t7", wb(7, 32'habc), quiet(8), 1);
    vo = cm(8, 7, 0, 32'habc, 0); vo.st = 1'b1;
    add("store_commit_t7", idle_in(), vo, 1);
    // Writebacks to an invalid tag and to tag 0 are ignored
    add("wb_invalid_t9", wb(9, 32'h99), quiet(8), 1);
    vi = wb(0, 32'h77); vi.rj = 9;
    vo = quiet(8); vo.rrj = 1'b0;
    add("rd_t9_ignored_wb", vi, vo, 1);
    // Mispredicted branch flush
    add("alloc_t8", al(ALU, 4), quiet(8), 1);
    add("alloc_br_t9", al(BRANCH, 0), quiet(9), 1);
    add("alloc_t10", al(ALU, 5), quiet(10), 1);
    add("alloc_t11", al(ALU, 6), quiet(11), 1);
    add("wb_t8", wb(8, 32'h88), quiet(12), 1);
    vi = wb(9, 32'h0); vi.mis = 1'b1; vi.tgt = 32'h400;
    add("commit_t8_wb_br", vi, cm(12, 8, 4, 32'h88, 1), 1);
    vi = al(ALU, 7); vi.cvld = 1'b1; vi.ctag = 10; vi.cval = 32'haa;
    vo = cm(12, 9, 0, 32'h0, 0); vo.ar = 1'b0; vo.fl = 1'b1; vo.rpc = 32'h400;
    add("flush_cycle", vi, vo, 1);
    vi = idle_in(); vi.rj = 10; vi.rk = 12;
    vo = quiet(1); vo.rrj = 1'b0; vo.rrk = 1'b0;
    add("after_flush", vi, vo, 1);
    add("alloc_t1_post", al(ALU, 8), quiet(1), 1);
    add("wb_t1_post", wb(1, 32'h1), quiet(2), 1);
    add("commit_t1_post", idle_in(), cm(2, 1, 8, 32'h1, 1), 1);
    add("empty_post", idle_in(), quiet(2), 1);
    // Correctly predicted branch: commits, no write, no flush
    add("alloc_br_t2", al(BRANCH, 0), quiet(2), 1);
    vi = wb(2, 32'h0); vi.tgt = 32'h500;
    add("wb_br_ok", vi, quiet(3), 1);
    add("commit_br_ok", idle_in(), cm(3, 2, 0, 32'h0, 0), 1);
    add("empty_end", idle_in(), quiet(3), 1);

    foreach (vecs[v]) begin
      @(negedge clk);
      apply(vecs[v].in);
      #1;
      act = {alloc_ready, alloc_tag, commit_valid, commit_ROB, commit_dest, commit_value,
             RegWrite, store_commit, flush, redirect_pc,
             rd_ready_j, rd_value_j, rd_ready_k, rd_value_k};
      if (vecs[v].chk) begin
        n_tests++;
        if (act !== vecs[v].exp) begin
          n_fail++;
          $display("FAIL %s: got ar=%b tag=%0d cv=%b rob=%0d dst=%0d val=%h rw=%b st=%b fl=%b pc=%h rj=%b/%h rk=%b/%h expected ar=%b tag=%0d cv=%b rob=%0d dst=%0d val=%h rw=%b st=%b fl=%b pc=%h rj=%b/%h rk=%b/%h",
                   vecs[v].name, act.ar, act.at, act.cv, act.crob, act.cdest, act.cval,
                   act.rw, act.st, act.fl, act.rpc, act.rrj, act.rvj, act.rrk, act.rvk,
                   vecs[v].exp.ar, vecs[v].exp.at, vecs[v].exp.cv, vecs[v].exp.crob,
                   vecs[v].exp.cdest, vecs[v].exp.cval, vecs[v].exp.rw, vecs[v].exp.st,
                   vecs[v].exp.fl, vecs[v].exp.rpc, vecs[v].exp.rrj, vecs[v].exp.rvj,
                   vecs[v].exp.rrk, vecs[v].exp.rvk);
        end
      end
    end

    // ---------------- fill, full, wrap, x0 destination ----------------
    @(negedge clk); apply(idle_in()); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      alloc_valid = 1'b1; alloc_kind = ALU; alloc_dest = 5'(i);
      #1;
      check($sformatf("fill_ready_%0d", i), 64'(alloc_ready), 64'd1);
      check($sformatf("fill_tag_%0d", i), 64'(alloc_tag), 64'(i));
      @(negedge clk);
    end
    alloc_valid = 1'b1; alloc_dest = 5'd20;
    #1;
    check("full_not_ready", 64'(alloc_ready), 64'd0);
    @(negedge clk);
    alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h101;
    #1;
    check("full_after_stray", 64'(alloc_ready), 64'd0);
    check("no_commit_yet", 64'(commit_valid), 64'd0);
    @(negedge clk);
    alloc_valid = 1'b1; alloc_dest = 5'd21; cdb_tag = 4'd2; cdb_value = 32'h102;
    #1;
    check("full_commit_t1", {60'd0, commit_valid, commit_ROB[2:0]}, {60'd0, 1'b1, 3'd1});
    check("full_commit_no_slot", 64'(alloc_ready), 64'd0);
    @(negedge clk);
    alloc_valid = 1'b1; alloc_dest = 5'd0; cdb_tag = 4'd3; cdb_value = 32'h103;
    #1;
    check("wrap_ready_tag", {alloc_ready, 59'd0, alloc_tag}, {1'b1, 59'd0, 4'd1});
    check("commit_t2_full", {commit_valid, 59'd0, commit_ROB}, {1'b1, 59'd0, 4'd2});
    @(negedge clk);
    alloc_valid = 1'b0;
    for (int k = 4; k <= 15; k++) begin
      cdb_tag = 4'(k); cdb_value = 32'h100 + 32'(k);
      #1;
      check($sformatf("drain_commit_%0d", k - 1),
            {RegWrite, commit_valid, 26'd0, commit_ROB, commit_value},
            {1'b1, 1'b1, 26'd0, 4'(k - 1), 32'h100 + 32'(k - 1)});
      @(negedge clk);
    end
    cdb_tag = 4'd1; cdb_value = 32'h1dd;
    #1;
    check("drain_commit_15", {commit_valid, 59'd0, commit_ROB}, {1'b1, 59'd0, 4'd15});
    @(negedge clk);
    cdb_valid = 1'b0;
    #1;
    check("x0_commit", {commit_valid, RegWrite, 26'd0, commit_ROB, commit_value},
          {1'b1, 1'b0, 26'd0, 4'd1, 32'h1dd});
    @(negedge clk);
    #1;
    check("drained_empty", {commit_valid, alloc_ready, 58'd0, alloc_tag},
          {1'b0, 1'b1, 58'd0, 4'd2});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer for the Tomasulo core. Allocates one ROB tag per issued instruction; the tag drives issue_ROB of the register status table and tags the reservation station.
Captures results from the CDB and serves operand values for tags that have completed but not yet committed.
Commits one instruction per cycle from the head, driving commit_ROB, commit_dest and RegWrite to the register status table and register file. On a mispredicted branch it raises flush.

Parameters:
XLEN, 32, data/PC width
TAG_W, 4, ROB tag width; capacity = 2^TAG_W-1 entries (tag 0 reserved = "ready/no producer")

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc_valid  in  1  issue stage presents an instruction
alloc_ready  out  1  ROB can accept (not full, no flush)
alloc_kind  in  2  rob_kind_t: ALU, LOAD, STORE, BRANCH
alloc_dest  in  5  architectural destination register
alloc_tag  out  TAG_W  tag that will be given (current tail)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  producing tag
cdb_value  in  XLEN  result value
cdb_mispredict  in  1  branch resolved mispredicted
cdb_target  in  XLEN  correct branch target
rd_tag_j, rd_tag_k  in  TAG_W  operand lookups (Q_j, Q_k from regstat)
rd_ready_j, rd_ready_k  out  1  value is available
rd_value_j, rd_value_k  out  XLEN  value for that tag
commit_valid  out  1  head retires this cycle
commit_ROB  out  TAG_W  head tag
commit_dest  out  5  head destination
commit_value  out  XLEN  head result
RegWrite  out  1  register-file write enable
store_commit  out  1  head store releases to memory
flush  out  1  mispredicted branch retiring; drives regstat reset
redirect_pc  out  XLEN  fetch redirect, valid with flush

Behaviour:
- Clock and reset: clk rising edge, reset synchronous active-high. Reset state: all entries invalid, head=tail=1, count=0.
- Reset values of outputs: alloc_ready=1, alloc_tag=1. commit_valid, RegWrite, store_commit and flush are 0. redirect_pc, commit_value and commit_ROB are 0.
- Entry fields: valid, ready, kind, dest, value, mispredict, target.
- Tags run 1..2^TAG_W-1. The increment wraps from 15 to 1 and never produces 0.
- Allocate:
  - Happens when alloc_valid & alloc_ready at the edge.
  - Entry[tail] is set valid, not ready, with kind and dest. tail advances and count++.
  - alloc_ready = (count < 15) & ~flush. This uses registered count, so when full, a same-cycle commit does not open a slot until the next cycle.
- Writeback:
  - Happens when cdb_valid and entry[cdb_tag] is valid at the edge.
  - Sets ready and latches value, mispredict and target.
  - Writeback to an invalid tag or to tag 0 is ignored.
  - STORE entries are written by the address/data unit through the CDB like any other producer.
- Commit:
  - Combinational from head. commit_valid = entry[head].valid & entry[head].ready.
  - Latency: earliest commit is the cycle after the writeback edge.
  - On commit, the entry is cleared at the edge, head advances and count--. Allocate and commit in the same cycle leave count unchanged.
  - RegWrite = commit_valid & kind∈{ALU,LOAD} & commit_dest≠0.
  - store_commit = commit_valid & kind==STORE.
- Flush:
  - flush = commit_valid & kind==BRANCH & mispredict. redirect_pc = target in that cycle.
  - At that edge: all entries are invalidated, head=tail=1, count=0.
  - Any same-cycle allocation or CDB writeback is discarded.
  - A correctly predicted branch commits with no register write.
- Read ports:
  - tag 0 gives ready=1, value=0.
  - Otherwise ready = entry.valid & entry.ready, and value = entry.value.
- Reset mid-operation overrides everything, including flush.

Optional Feature:
ROB_CDB_BYPASS_EN:
- Defined: a read port whose tag equals cdb_tag while cdb_valid returns ready=1 and value=cdb_value in the same cycle.
- Undefined: read ports see only stored entries, so the value appears one cycle after the writeback.

Decomposition:
- structs.svh additions:
  - rob_kind_t enum (ALU=0, LOAD=1, STORE=2, BRANCH=3)
  - rob_entry_t struct
  - constants ROB_TAG_W=4 and ROB_NULL_TAG=0
- Sub-module rob_tag_incr: combinational wrap-skipping-zero incrementer, used for head and tail.

Test Plan:
- Reset, 15 ALU allocs -> alloc_tag 1..15. alloc_ready=0 after the 15th; a 16th alloc_valid is not accepted and count stays 15.
- Alloc tags 1,2,3 (dest x5,x6,x7); CDB tag3=0x33, tag1=0x11, tag2=0x22 on separate cycles -> tag1 commits the cycle after its writeback; tags 2,3 commit on consecutive cycles after tag2's writeback. Each has RegWrite=1 and the correct commit_dest/value.
- Commit 15 entries then allocate -> alloc_tag=1 (wraps, skips 0). Alloc dest x0, write back -> commit_valid=1, RegWrite=0.
- Branch tag2 mispredicted with target 0x400, younger tags 3,4, alloc_valid during the flush cycle -> flush=1 for one cycle with redirect_pc=0x400. Next cycle: count=0, alloc_tag=1, the stray alloc is dropped.
- Read ports: rd_tag_j=0 -> ready=1, value=0. Written tag 5 -> ready=1 with its value. Tag 6 with cdb_tag=6 in the same cycle -> ready=1 only with ROB_CDB_BYPASS_EN.
- STORE head written back -> store_commit=1, RegWrite=0, head advances.
